// File: rtl/chip_dff_checker_if.sv
// Host handshake and socket pins of the 7474 D-flip-flop tester.
// slave = tester side, master = host/socket side.
interface chip_dff_checker_if #(
    parameter int unsigned NUM_CH = 2
);
    logic              Run;
    logic              DISP_RSLT;
    logic              Done;
    logic              RSLT;
    logic [NUM_CH-1:0] fail_ch;
    logic [3:0]        fail_vec;
    logic [NUM_CH-1:0] dut_q;
    logic [NUM_CH-1:0] dut_qn;
    logic [NUM_CH-1:0] dut_d;
    logic [NUM_CH-1:0] dut_ck;
    logic [NUM_CH-1:0] dut_pre_n;
    logic [NUM_CH-1:0] dut_clr_n;

    modport master (
        output Run, DISP_RSLT, dut_q, dut_qn,
        input  Done, RSLT, fail_ch, fail_vec, dut_d, dut_ck, dut_pre_n, dut_clr_n
    );

    modport slave (
        input  Run, DISP_RSLT, dut_q, dut_qn,
        output Done, RSLT, fail_ch, fail_vec, dut_d, dut_ck, dut_pre_n, dut_clr_n
    );
endinterface

// File: rtl/chip_dff_checker.sv
// Exhaustive 7474 tester: walks 16 (or 4) pin vectors, compares Q/QN per channel
// against a golden flip-flop model and reports through Run/Done/RSLT/DISP_RSLT.
module chip_dff_checker #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter bit          TEST_ASYNC = 1'b1
) (
    input logic               Clk,
    input logic               Reset,
    chip_dff_checker_if.slave bus
);
    localparam int unsigned CW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [3:0]  LAST_V = TEST_ASYNC ? 4'd15 : 4'd3;

    typedef enum logic [2:0] {HALTED, SET, DRIVE, SETTLE, CHECK, DONE_S} state_t;

    state_t            state;
    logic [3:0]        v;
    logic [CW-1:0]     cnt;
    logic [NUM_CH-1:0] model_q, model_qn;
    logic [NUM_CH-1:0] vec_d, vec_ck, vec_pre_n, vec_clr_n;
    logic [NUM_CH-1:0] nxt_q, nxt_qn, mism;

    // Vector decode and golden next state; the currently driven CK is the "previous" CK.
    always_comb begin
        vec_d     = '0;
        vec_ck    = '0;
        vec_pre_n = '1;
        vec_clr_n = '1;
        nxt_q     = model_q;
        nxt_qn    = model_qn;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            vec_d[c]     = v[1] ^ c[0];
            vec_ck[c]    = v[0];
            vec_pre_n[c] = TEST_ASYNC ? ~v[2] : 1'b1;
            vec_clr_n[c] = TEST_ASYNC ? ~v[3] : 1'b1;
            if (!vec_pre_n[c] && !vec_clr_n[c]) begin
                nxt_q[c]  = 1'b1;
                nxt_qn[c] = 1'b1;
            end else if (!vec_pre_n[c]) begin
                nxt_q[c]  = 1'b1;
                nxt_qn[c] = 1'b0;
            end else if (!vec_clr_n[c]) begin
                nxt_q[c]  = 1'b0;
                nxt_qn[c] = 1'b1;
            end else if (vec_ck[c] && !bus.dut_ck[c]) begin
                nxt_q[c]  = vec_d[c];
                nxt_qn[c] = ~vec_d[c];
            end
        end
        mism = (bus.dut_q ^ model_q) | (bus.dut_qn ^ model_qn);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= HALTED;
            v             <= '0;
            cnt           <= '0;
            model_q       <= '0;
            model_qn      <= '1;
            bus.Done      <= 1'b0;
            bus.RSLT      <= 1'b0;
            bus.fail_ch   <= '0;
            bus.fail_vec  <= '0;
            bus.dut_d     <= '0;
            bus.dut_ck    <= '0;
            bus.dut_pre_n <= '1;
            bus.dut_clr_n <= '1;
        end else begin
            case (state)
                HALTED: if (bus.Run) state <= SET;
                SET: begin
                    bus.RSLT      <= 1'b1;
                    bus.fail_ch   <= '0;
                    bus.fail_vec  <= '0;
                    v             <= '0;
                    bus.dut_pre_n <= '1;
                    bus.dut_clr_n <= '0;
                    bus.dut_ck    <= '0;
                    bus.dut_d     <= '0;
                    model_q       <= '0;
                    model_qn      <= '1;
                    state         <= DRIVE;
                end
                DRIVE: begin
                    bus.dut_d     <= vec_d;
                    bus.dut_ck    <= vec_ck;
                    bus.dut_pre_n <= vec_pre_n;
                    bus.dut_clr_n <= vec_clr_n;
                    model_q       <= nxt_q;
                    model_qn      <= nxt_qn;
                    cnt           <= '0;
                    state         <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) state <= CHECK;
                    else                            cnt   <= cnt + 1'b1;
                end
                CHECK: begin
                    // RSLT still high means no earlier mismatch in this run.
                    if (|mism) begin
                        bus.RSLT    <= 1'b0;
                        bus.fail_ch <= bus.fail_ch | mism;
                        if (bus.RSLT) bus.fail_vec <= v;
                    end
                    if (v == LAST_V) begin
                        bus.Done      <= 1'b1;
                        bus.dut_d     <= '0;
                        bus.dut_ck    <= '0;
                        bus.dut_pre_n <= '1;
                        bus.dut_clr_n <= '1;
                        state         <= DONE_S;
                    end else begin
                        v     <= v + 4'd1;
                        state <= DRIVE;
                    end
                end
                DONE_S: begin
                    if (bus.DISP_RSLT) begin
                        bus.Done <= 1'b0;
                        state    <= HALTED;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_chip_dff_checker.sv
// Bench for chip_dff_checker: three configurations, emulated 7474 sockets with
// injectable output faults, results checked against a vector-level reference.
module tb_chip_dff_checker;
    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic run_r  [3] = '{1'b0, 1'b0, 1'b0};
    logic disp_r [3] = '{1'b0, 1'b0, 1'b0};

    // Socket faults, shared by all sockets (one configuration is exercised at a time).
    logic [7:0] f_sqm = '0, f_sqv = '0, f_sqnm = '0, f_sqnv = '0;
    logic       f_short = 1'b0;

    chip_dff_checker_if #(.NUM_CH(2)) ifa ();
    chip_dff_checker_if #(.NUM_CH(2)) ifb ();
    chip_dff_checker_if #(.NUM_CH(4)) ifc ();

    chip_dff_checker #(.NUM_CH(2), .SETTLE_CYC(4), .TEST_ASYNC(1'b1)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa.slave));
    chip_dff_checker #(.NUM_CH(2), .SETTLE_CYC(4), .TEST_ASYNC(1'b0)) dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb.slave));
    chip_dff_checker #(.NUM_CH(4), .SETTLE_CYC(1), .TEST_ASYNC(1'b1)) dut_c (.Clk(Clk), .Reset(Reset), .bus(ifc.slave));

    function automatic int nch_of(input int s);    return (s == 2) ? 4 : 2;   endfunction
    function automatic int settle_of(input int s); return (s == 2) ? 1 : 4;   endfunction
    function automatic int nv_of(input int s);     return (s == 1) ? 4 : 16;  endfunction
    function automatic bit async_of(input int s);  return (s != 1);           endfunction
    function automatic logic [7:0] chmask(input int s); return 8'((1 << nch_of(s)) - 1); endfunction

    assign ifa.Run = run_r[0];  assign ifa.DISP_RSLT = disp_r[0];
    assign ifb.Run = run_r[1];  assign ifb.DISP_RSLT = disp_r[1];
    assign ifc.Run = run_r[2];  assign ifc.DISP_RSLT = disp_r[2];

    // Emulated 7474 sockets: async PRE/CLR dominate, otherwise capture D on CK rise.
    logic [7:0] sq [3], sqn [3], sl [3];
    logic [7:0] qo [3], qno [3];

    task automatic emu(input int s, input logic [7:0] d, input logic [7:0] ck,
                       input logic [7:0] pre_n, input logic [7:0] clr_n);
        for (int c = 0; c < 8; c++) begin
            if (!pre_n[c] && !clr_n[c]) begin sq[s][c] = 1'b1; sqn[s][c] = 1'b1; end
            else if (!pre_n[c])         begin sq[s][c] = 1'b1; sqn[s][c] = 1'b0; end
            else if (!clr_n[c])         begin sq[s][c] = 1'b0; sqn[s][c] = 1'b1; end
            else if (ck[c] === 1'b1 && sl[s][c] === 1'b0) begin
                sq[s][c] = d[c]; sqn[s][c] = ~d[c];
            end
            sl[s][c] = ck[c];
        end
    endtask

    always @(ifa.dut_d, ifa.dut_ck, ifa.dut_pre_n, ifa.dut_clr_n)
        emu(0, 8'(ifa.dut_d), 8'(ifa.dut_ck), 8'(ifa.dut_pre_n), 8'(ifa.dut_clr_n));
    always @(ifb.dut_d, ifb.dut_ck, ifb.dut_pre_n, ifb.dut_clr_n)
        emu(1, 8'(ifb.dut_d), 8'(ifb.dut_ck), 8'(ifb.dut_pre_n), 8'(ifb.dut_clr_n));
    always @(ifc.dut_d, ifc.dut_ck, ifc.dut_pre_n, ifc.dut_clr_n)
        emu(2, 8'(ifc.dut_d), 8'(ifc.dut_ck), 8'(ifc.dut_pre_n), 8'(ifc.dut_clr_n));

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            qo[s]  = (sq[s] & ~f_sqm) | (f_sqv & f_sqm);
            qno[s] = (sqn[s] & ~f_sqnm) | (f_sqnv & f_sqnm);
            if (f_short) begin
                qno[s][0] = sqn[s][0] & sqn[s][1];
                qno[s][1] = qno[s][0];
            end
        end
    end

    assign ifa.dut_q = qo[0][1:0];  assign ifa.dut_qn = qno[0][1:0];
    assign ifb.dut_q = qo[1][1:0];  assign ifb.dut_qn = qno[1][1:0];
    assign ifc.dut_q = qo[2][3:0];  assign ifc.dut_qn = qno[2][3:0];

    typedef struct packed {
        logic       done;
        logic       rslt;
        logic [7:0] fail_ch;
        logic [3:0] fail_vec;
        logic [7:0] d, ck, pre_n, clr_n;
    } obs_t;

    typedef struct packed {
        logic       rslt;
        logic [7:0] fail_ch;
        logic [3:0] fail_vec;
    } res_t;

    function automatic obs_t sample(input int s);
        obs_t o;
        case (s)
            0: begin
                o.done = ifa.Done; o.rslt = ifa.RSLT; o.fail_ch = 8'(ifa.fail_ch); o.fail_vec = ifa.fail_vec;
                o.d = 8'(ifa.dut_d); o.ck = 8'(ifa.dut_ck); o.pre_n = 8'(ifa.dut_pre_n); o.clr_n = 8'(ifa.dut_clr_n);
            end
            1: begin
                o.done = ifb.Done; o.rslt = ifb.RSLT; o.fail_ch = 8'(ifb.fail_ch); o.fail_vec = ifb.fail_vec;
                o.d = 8'(ifb.dut_d); o.ck = 8'(ifb.dut_ck); o.pre_n = 8'(ifb.dut_pre_n); o.clr_n = 8'(ifb.dut_clr_n);
            end
            default: begin
                o.done = ifc.Done; o.rslt = ifc.RSLT; o.fail_ch = 8'(ifc.fail_ch); o.fail_vec = ifc.fail_vec;
                o.d = 8'(ifc.dut_d); o.ck = 8'(ifc.dut_ck); o.pre_n = 8'(ifc.dut_pre_n); o.clr_n = 8'(ifc.dut_clr_n);
            end
        endcase
        return o;
    endfunction

    function automatic res_t res_of(input obs_t o);
        return {o.rslt, o.fail_ch, o.fail_vec};
    endfunction

    // Reference: replays the vector list on an ideal flip-flop, applies the socket faults.
    function automatic res_t ref_run(input int s);
        res_t r;
        bit   q [8];
        bit   qn [8];
        bit   oq, oqn, hit, dd;
        int   ck, pre, clr, ckp;
        r.rslt = 1'b1; r.fail_ch = '0; r.fail_vec = '0;
        for (int c = 0; c < 8; c++) begin q[c] = 1'b0; qn[c] = 1'b1; end
        ckp = 0;
        for (int v = 0; v < nv_of(s); v++) begin
            ck  = v & 1;
            pre = async_of(s) ? 1 - ((v >> 2) & 1) : 1;
            clr = async_of(s) ? 1 - ((v >> 3) & 1) : 1;
            hit = 1'b0;
            for (int c = 0; c < nch_of(s); c++) begin
                dd = 1'(((v >> 1) ^ c) & 1);
                if (pre == 0 && clr == 0)      begin q[c] = 1'b1; qn[c] = 1'b1; end
                else if (pre == 0)             begin q[c] = 1'b1; qn[c] = 1'b0; end
                else if (clr == 0)             begin q[c] = 1'b0; qn[c] = 1'b1; end
                else if (ck == 1 && ckp == 0)  begin q[c] = dd;   qn[c] = !dd;  end
            end
            ckp = ck;
            for (int c = 0; c < nch_of(s); c++) begin
                oq  = f_sqm[c]  ? f_sqv[c]  : q[c];
                oqn = f_sqnm[c] ? f_sqnv[c] : qn[c];
                if (f_short && c < 2) oqn = qn[0] & qn[1];
                if (oq != q[c] || oqn != qn[c]) begin r.fail_ch[c] = 1'b1; hit = 1'b1; end
            end
            if (hit && r.rslt) begin r.rslt = 1'b0; r.fail_vec = 4'(v); end
        end
        return r;
    endfunction

    // Starts a run, tracks pin activity per cycle, returns cycles from the Run-sampling edge to Done.
    task automatic do_run(input int s, input bit pulse_mid, output int cycles, output int pin_err, output obs_t fin);
        int per, last, v;
        logic [7:0] m, ed, eck, ep, ec;
        obs_t o;
        per = settle_of(s) + 2;
        last = 1 + nv_of(s) * per;
        m = chmask(s);
        cycles = -1; pin_err = 0;
        @(negedge Clk); run_r[s] = 1'b1;
        @(posedge Clk);
        @(negedge Clk); run_r[s] = 1'b0;
        for (int k = 1; k <= last + 20; k++) begin
            @(posedge Clk); #1;
            o = sample(s);
            fin = o;
            if (k == 1) begin
                ed = '0; eck = '0; ep = m; ec = '0;
            end else if (k >= last) begin
                ed = '0; eck = '0; ep = m; ec = m;
            end else begin
                v = (k - 2) / per;
                ed = '0;
                for (int c = 0; c < nch_of(s); c++) ed[c] = 1'(((v >> 1) ^ c) & 1);
                eck = (v & 1) ? m : '0;
                ep  = (async_of(s) && ((v >> 2) & 1)) ? '0 : m;
                ec  = (async_of(s) && ((v >> 3) & 1)) ? '0 : m;
            end
            if ({o.d, o.ck, o.pre_n, o.clr_n} !== {ed, eck, ep, ec}) pin_err++;
            run_r[s]  = pulse_mid && (k == last / 2);
            disp_r[s] = pulse_mid && (k == last / 2);
            if (o.done === 1'b1) begin cycles = k; break; end
        end
        run_r[s] = 1'b0; disp_r[s] = 1'b0;
    endtask

    task automatic ack(input int s);
        @(negedge Clk); disp_r[s] = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk); disp_r[s] = 1'b0;
    endtask

    task automatic clear_faults();
        f_sqm = '0; f_sqv = '0; f_sqnm = '0; f_sqnv = '0; f_short = 1'b0;
    endtask

    task automatic random_fault(input int s);
        int ch;
        logic val;
        clear_faults();
        ch  = $urandom_range(0, nch_of(s) - 1);
        val = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin f_sqm[ch] = 1'b1; f_sqv[ch] = val; end
        else                           begin f_sqnm[ch] = 1'b1; f_sqnv[ch] = val; end
    endtask

    task automatic test_reset();
        obs_t o, e;
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        for (int s = 0; s < 3; s++) begin
            o = sample(s);
            e = '0; e.pre_n = chmask(s); e.clr_n = chmask(s);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_state dut%0d got %h want %h", s, o, e); end
        end
        Reset = 1'b0;
    endtask

    task automatic run_and_compare(input string name, input int s, input bit pulse_mid);
        int cyc, perr;
        obs_t o;
        res_t r;
        r = ref_run(s);
        repeat ($urandom_range(0, 5)) @(negedge Clk);
        do_run(s, pulse_mid, cyc, perr, o);
        n_checks++;
        if (cyc != 1 + nv_of(s) * (settle_of(s) + 2)) begin
            n_fail++; $display("FAIL %s_latency got %0d want %0d", name, cyc, 1 + nv_of(s) * (settle_of(s) + 2));
        end
        n_checks++;
        if (perr != 0) begin n_fail++; $display("FAIL %s_pins got %0d bad cycles want 0", name, perr); end
        n_checks++;
        if (res_of(o) !== r) begin n_fail++; $display("FAIL %s_result got %h want %h", name, res_of(o), r); end
    endtask

    task automatic test_ideal();
        clear_faults();
        run_and_compare("ideal", 0, 1'b0);
        ack(0);
        n_checks++;
        if (ifa.Done !== 1'b0) begin n_fail++; $display("FAIL ideal_ack got Done=%b want 0", ifa.Done); end
    endtask

    task automatic test_stuck();
        clear_faults();
        f_sqm[1] = 1'b1; f_sqv[1] = 1'b0;
        run_and_compare("stuck_q1", 0, 1'b0);
        n_checks++;
        if ({ifa.RSLT, ifa.fail_ch, ifa.fail_vec} !== {1'b0, 2'b10, 4'd1}) begin
            n_fail++; $display("FAIL stuck_q1_spec got %b/%b/%0d want 0/10/1", ifa.RSLT, ifa.fail_ch, ifa.fail_vec);
        end
        ack(0);
        for (int i = 0; i < 4; i++) begin
            random_fault(0);
            run_and_compare("stuck_rand", 0, 1'b0);
            ack(0);
        end
    endtask

    task automatic test_async_off();
        clear_faults();
        run_and_compare("async_off", 1, 1'b0);
        ack(1);
        random_fault(1);
        run_and_compare("async_off_fault", 1, 1'b0);
        ack(1);
    endtask

    task automatic test_disp();
        int cyc, perr;
        obs_t o;
        res_t r;
        clear_faults();
        random_fault(0);
        r = ref_run(0);
        do_run(0, 1'b0, cyc, perr, o);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            o = sample(0);
            n_checks++;
            if (o.done !== 1'b1 || res_of(o) !== r) begin
                n_fail++; $display("FAIL disp_hold cycle %0d got done=%b res=%h want done=1 res=%h", i, o.done, res_of(o), r);
            end
        end
        @(negedge Clk); disp_r[0] = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (ifa.Done !== 1'b0) begin n_fail++; $display("FAIL disp_release got Done=%b want 0", ifa.Done); end
        @(negedge Clk); disp_r[0] = 1'b0;

        clear_faults();
        do_run(0, 1'b0, cyc, perr, o);
        @(negedge Clk); disp_r[0] = 1'b1; run_r[0] = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (ifa.Done !== 1'b0) begin n_fail++; $display("FAIL disp_and_run got Done=%b want 0", ifa.Done); end
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge Clk); #1;
            if (k == 1) begin disp_r[0] = 1'b0; run_r[0] = 1'b0; end
            if (ifa.Done === 1'b1) begin cyc = k; break; end
        end
        n_checks++;
        if (cyc != 98) begin n_fail++; $display("FAIL disp_and_run_restart got %0d want 98", cyc); end
        ack(0);
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int cyc, perr;
        clear_faults();
        f_sqm[1] = 1'b1; f_sqv[1] = 1'b0;
        @(negedge Clk); run_r[0] = 1'b1;
        @(posedge Clk);
        @(negedge Clk); run_r[0] = 1'b0;
        repeat (46) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({ifa.RSLT, ifa.fail_ch, ifa.fail_vec, ifa.Done} !== {1'b0, 2'b10, 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_pre got %b/%b/%0d/%b want 0/10/1/0", ifa.RSLT, ifa.fail_ch, ifa.fail_vec, ifa.Done);
        end
        Reset = 1'b1;
        #1;
        o = sample(0);
        e = '0; e.pre_n = chmask(0); e.clr_n = chmask(0);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_mid_abort got %h want %h", o, e); end
        @(negedge Clk); Reset = 1'b0;
        clear_faults();
        run_and_compare("reset_mid_rerun", 0, 1'b0);
        ack(0);
    endtask

    task automatic test_num_ch4();
        clear_faults();
        f_short = 1'b1;
        run_and_compare("ch4_short", 2, 1'b1);
        n_checks++;
        if (ifc.fail_ch[3:2] !== 2'b00 || ifc.fail_ch[1:0] === 2'b00) begin
            n_fail++; $display("FAIL ch4_short_chan got %b want only bits 0/1 set", ifc.fail_ch);
        end
        ack(2);
        clear_faults();
        run_and_compare("ch4_ideal", 2, 1'b1);
        ack(2);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin sq[s] = '0; sqn[s] = '1; sl[s] = '0; end
        test_reset();
        test_ideal();
        test_stuck();
        test_async_off();
        test_disp();
        test_reset_mid();
        test_num_ch4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired after %0t want finish earlier", $time);
        $fatal(1, "watchdog");
    end
endmodule
